csa_result_stage: RTL and testbench
===================================

// Module: csa_result_stage
// PURPOSE
//   Registered result stage directly downstream of the N-bit carry-save adder.
//   Captures {S, cout, OF} under a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
//   Optionally saturates signed overflow results and keeps sticky and counted overflow status.
//   Decouples adder timing from the consumer; no combinational path from input to output.
// PARAMETERS
//   N      32  datapath width; must match the adder width
//   DEPTH  4   FIFO entries; power of 2, >= 2
//   SAT    1   1: saturate signed result when in_of=1; 0: pass the raw sum through
// PORTS
//   clk         in   1              single clock, rising edge
//   rst_n       in   1              asynchronous, active-low reset
//   in_valid    in   1              adder result present
//   in_ready    out  1              stage can accept (registered: count < DEPTH)
//   in_sum      in   N              adder S
//   in_cout     in   1              adder cout
//   in_of       in   1              adder OF (signed overflow)
//   out_valid   out  1              head entry valid
//   out_ready   in   1              consumer accepts head entry
//   out_data    out  N              head result (post-saturation); 0 when out_valid=0
//   out_cout    out  1              head carry-out; 0 when out_valid=0
//   out_of      out  1              head overflow flag; 0 when out_valid=0
//   count       out  $clog2(DEPTH+1)  current occupancy
//   sticky_of   out  1              set by any accepted item with in_of=1
//   of_count    out  16             saturating count of accepted overflow items
//   clr_sticky  in   1              synchronous clear of sticky_of and of_count
// BEHAVIOUR
//   Reset (async, rst_n=0): rd/wr pointers=0; count=0; out_valid=0; in_ready=1 (after release);
//     sticky_of=0; of_count=0. FIFO storage is not reset.
//   Reset mid-operation: all buffered entries are discarded immediately.
//     No output handshake completes while rst_n=0.
//   push = in_valid & in_ready; pop = out_valid & out_ready. Both take effect at the clk edge.
//   in_ready = (count != DEPTH), derived only from registers; it never depends on out_ready.
//     When the FIFO is full, an input is not accepted even if a pop happens in the same cycle.
//   in_valid while in_ready=0: the input is ignored, no flags change, and the source must hold.
//   out_valid = (count != 0). The head entry is stable while out_valid & ~out_ready.
//   Latency: accept at edge k -> out_valid=1 after edge k (visible in cycle k+1).
//     No same-cycle bypass.
//   Count rules:
//     push & pop: count unchanged.
//     push only: count+1.
//     pop only: count-1.
//     neither: count held.
//   Pointers advance mod DEPTH. Wrap-around is transparent; order is strictly FIFO.
//   Stored value per entry: {data, cout, of} with of = in_of and cout = in_cout (unmodified).
//   Saturation (SAT=1 and in_of=1):
//     in_sum[N-1]=1 -> data = {1'b0,{N-1{1'b1}}} (max positive).
//     in_sum[N-1]=0 -> data = {1'b1,{N-1{1'b0}}} (min negative).
//     Otherwise data = in_sum.
//   Flags update on accepted items only:
//     sticky_of next = (sticky_of & ~clr_sticky) | (push & in_of).
//     of_count next = (clr_sticky ? 0 : of_count) + (push & in_of), saturating at 16'hFFFF.
//     When clr_sticky and an overflow push coincide, set wins: sticky_of=1, of_count=1.
// TESTING
//   1 Reset: stream items, drop rst_n mid-burst -> out_valid=0, count=0, sticky_of=0,
//     of_count=0 asynchronously; the next item after release is the first item out.
//   2 Single item: in_sum=32'h5, cout=1, of=0, out_ready=1 -> next cycle out_valid=1,
//     out_data=32'h5, out_cout=1; following cycle out_valid=0, out_data=0.
//   3 Saturation: SAT=1, in_sum=32'h8000_0000, of=1 -> out_data=32'h7FFF_FFFF, out_of=1,
//     sticky_of=1, of_count=1; in_sum=32'h7FFF_FFFE, of=1 -> 32'h8000_0000.
//     SAT=0, same inputs -> raw sums.
//   4 Full: out_ready=0, push 4 items (DEPTH=4) -> count=4, in_ready=0, 5th item held;
//     assert out_ready with 5th valid -> pop then accept; drain order matches input.
//   5 Stream/wrap: 20 items, random in_valid/out_ready -> data order preserved across
//     pointer wrap; push&pop at count=2 keeps count=2.
//   6 Flags: clr_sticky coincident with an overflow push -> sticky_of=1, of_count=1;
//     force 65536 overflows -> of_count holds 16'hFFFF.

Source files
------------

// File: rtl/csa_result_stage.sv
// ============================================================================
// Module      : csa_result_stage
// Description : Registered result FIFO behind the carry-save adder, with
//               optional signed saturation and sticky/counted overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_result_stage #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int SAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_sum,
    input  logic                       in_cout,
    input  logic                       in_of,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic                       out_cout,
    output logic                       out_of,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       sticky_of,
    output logic [15:0]                of_count,
    input  logic                       clr_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = N + 2;

    localparam logic [N-1:0]  c_max_pos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  c_min_neg = {1'b1, {(N-1){1'b0}}};
    localparam logic [CW-1:0] c_full    = CW'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_sticky;
    logic [15:0]   r_of_count;

    logic          w_push;
    logic          w_pop;
    logic          w_out_valid;
    logic [N-1:0]  w_data;
    logic [EW-1:0] w_head;
    logic [15:0]   w_of_base;

    assign in_ready    = (r_count != c_full);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Overflow saturates towards the sign opposite to the wrapped sum.
    always_comb begin
        w_data = in_sum;
        if ((SAT != 0) && in_of) begin
            w_data = in_sum[N-1] ? c_max_pos : c_min_neg;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_data, in_cout, in_of};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear coinciding with an overflow push still records that push.
    assign w_of_base = clr_sticky ? 16'h0000 : r_of_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky   <= 1'b0;
            r_of_count <= '0;
        end else begin
            r_sticky <= (r_sticky & ~clr_sticky) | (w_push & in_of);
            if (w_push && in_of && (w_of_base != 16'hFFFF)) begin
                r_of_count <= w_of_base + 16'h0001;
            end else begin
                r_of_count <= w_of_base;
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_head[EW-1:2] : '0;
    assign out_cout  = w_out_valid & w_head[1];
    assign out_of    = w_out_valid & w_head[0];
    assign count     = r_count;
    assign sticky_of = r_sticky;
    assign of_count  = r_of_count;

endmodule

`default_nettype wire

// File: tb/tb_csa_result_stage.sv
// ============================================================================
// Module      : tb_csa_result_stage
// Description : Randomised bench for csa_result_stage against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_csa_result_stage;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [N-1:0]  in_sum = '0;
    logic          in_cout = 1'b0;
    logic          in_of = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_sticky = 1'b0;

    logic          in_ready, out_valid, out_cout, out_of, sticky_of;
    logic [N-1:0]  out_data;
    logic [CW-1:0] count;
    logic [15:0]   of_count;

    logic          raw_in_ready, raw_out_valid, raw_out_cout, raw_out_of, raw_sticky_of;
    logic [N-1:0]  raw_out_data;
    logic [CW-1:0] raw_count;
    logic [15:0]   raw_of_count;

    always #5 clk = ~clk;

    csa_result_stage #(.N(N), .DEPTH(DEPTH), .SAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_of(in_of),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cout(out_cout), .out_of(out_of), .count(count),
        .sticky_of(sticky_of), .of_count(of_count), .clr_sticky(clr_sticky)
    );

    csa_result_stage #(.N(N), .DEPTH(DEPTH), .SAT(0)) u_dut_raw (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(raw_in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_of(in_of),
        .out_valid(raw_out_valid), .out_ready(out_ready), .out_data(raw_out_data),
        .out_cout(raw_out_cout), .out_of(raw_out_of), .count(raw_count),
        .sticky_of(raw_sticky_of), .of_count(raw_of_count), .clr_sticky(clr_sticky)
    );

    typedef struct packed {
        logic [31:0] sat;
        logic [31:0] raw;
        logic        cout;
        logic        of;
    } item_t;

    item_t q[$];
    bit    m_sticky;
    int    m_ofc;
    bit    last_push;
    int    n_checks = 0;
    int    n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] saturate(input logic [31:0] s, input bit of);
        if (!of) return s;
        return ($signed(s) < 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endfunction

    task automatic drive(input bit v, input logic [31:0] s, input bit c, input bit o,
                         input bit ordy, input bit clr);
        in_valid = v; in_sum = s; in_cout = c; in_of = o;
        out_ready = ordy; clr_sticky = clr;
    endtask

    // Compare outputs mid-cycle, then advance the model across the coming edge.
    task automatic step();
        bit    e_v, push, pop;
        item_t it;
        @(negedge clk);
        e_v = (q.size() != 0);
        check("out_valid", out_valid, e_v);
        check("in_ready", in_ready, q.size() != DEPTH);
        check("count", count, q.size());
        check("out_data", out_data, e_v ? q[0].sat : 32'h0);
        check("out_cout", out_cout, e_v ? q[0].cout : 1'b0);
        check("out_of", out_of, e_v ? q[0].of : 1'b0);
        check("raw_out_data", raw_out_data, e_v ? q[0].raw : 32'h0);
        check("sticky_of", sticky_of, m_sticky);
        check("of_count", of_count, m_ofc);
        push = in_valid && (q.size() != DEPTH);
        pop  = e_v && out_ready;
        m_sticky = (m_sticky && !clr_sticky) || (push && in_of);
        if (clr_sticky) m_ofc = 0;
        if (push && in_of && m_ofc < 65535) m_ofc++;
        if (pop) void'(q.pop_front());
        if (push) begin
            it.sat = saturate(in_sum, in_of); it.raw = in_sum;
            it.cout = in_cout; it.of = in_of;
            q.push_back(it);
        end
        last_push = push;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_sticky", sticky_of, 1'b0);
        check("rst_of_count", of_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); m_sticky = 0; m_ofc = 0; last_push = 0;
        step();

        // Single item
        drive(1, 32'h5, 1, 0, 1, 0); step();
        drive(0, 0, 0, 0, 1, 0); step(); step();

        // Saturation in both directions, raw copy checked on the SAT=0 instance
        drive(1, 32'h8000_0000, 0, 1, 1, 0); step();
        drive(1, 32'h7FFF_FFFE, 0, 1, 1, 0); step();
        drive(0, 0, 0, 0, 1, 0); step(); step();

        // Full FIFO with held fifth item
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + i, i[0], 0, 0, 0); step();
        end
        drive(1, 32'h104, 1, 0, 0, 0); step(); step();
        check("full_count", count, 3'd4);
        check("full_in_ready", in_ready, 1'b0);
        out_ready = 1; step();
        check("fifth_held", last_push, 1'b0);
        step();
        check("fifth_taken", last_push, 1'b1);
        drive(0, 0, 0, 0, 1, 0);
        repeat (6) step();

        // Push and pop together at occupancy two
        drive(1, 32'hA1, 0, 0, 0, 0); step();
        drive(1, 32'hA2, 0, 0, 0, 0); step();
        drive(1, 32'hA3, 0, 0, 1, 0); step();
        check("pushpop_count", count, 3'd2);
        drive(0, 0, 0, 0, 1, 0); repeat (3) step();

        // Random stream across pointer wraps, source holds when stalled
        last_push = 1;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_push) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_sum   = $urandom;
                in_cout  = $urandom_range(0, 1);
                in_of    = ($urandom_range(0, 3) == 0);
            end
            out_ready  = $urandom_range(0, 1);
            clr_sticky = ($urandom_range(0, 15) == 0);
            step();
        end

        // Asynchronous reset mid-burst
        drive(0, 0, 0, 0, 1, 0); repeat (5) step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h200 + i, 0, 1, 0, 0); step();
        end
        drive(0, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_count", count, 0);
        check("arst_sticky", sticky_of, 1'b0);
        check("arst_of_count", of_count, 0);
        q.delete(); m_sticky = 0; m_ofc = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 32'h300, 1, 0, 1, 0); step();
        drive(0, 0, 0, 0, 1, 0); step(); step();

        // Clear coinciding with an overflow push
        drive(1, 32'h1, 0, 1, 1, 0); step();
        drive(1, 32'h2, 0, 1, 1, 1); step();
        drive(0, 0, 0, 0, 1, 0); step();
        check("clr_set_ofc", of_count, 16'd1);

        // Saturation of the overflow counter
        for (int i = 0; i < 65540; i++) begin
            drive(1, $urandom, 0, 1, 1, 0); step();
        end
        drive(0, 0, 0, 0, 1, 0); step(); step();
        check("ofc_sat", of_count, 16'hFFFF);
        clr_sticky = 1; step();
        clr_sticky = 0; step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
